// File: rtl/mreq_exec_pkg.sv
// Shared definitions for the memory-request executor: the packed request
// layout and helpers that decode the word-size field.
package mreq_exec_pkg;

    localparam int MREQ_NBIT = 44;

    localparam logic [1:0] MREQ_WSIZE_1B = 2'd0;
    localparam logic [1:0] MREQ_WSIZE_2B = 2'd1;
    localparam logic [1:0] MREQ_WSIZE_4B = 2'd2;

    typedef struct packed {
        logic        wr;
        logic        aincr;
        logic [1:0]  wsize;
        logic [7:0]  wcount;
        logic [31:0] addr;
    } mreq_t;

    function automatic mreq_t unpack_mreq(input logic [MREQ_NBIT-1:0] raw);
        return mreq_t'(raw);
    endfunction

    // Index of the last byte of a word; the reserved code 3 behaves as 2 bytes.
    function automatic logic [1:0] wsize_last_byte(input logic [1:0] wsize);
        case (wsize)
            MREQ_WSIZE_1B: return 2'd0;
            MREQ_WSIZE_2B: return 2'd1;
            MREQ_WSIZE_4B: return 2'd3;
            default:       return 2'd1;
        endcase
    endfunction

    function automatic logic [3:0] wsize_sel(input logic [1:0] wsize);
        case (wsize)
            MREQ_WSIZE_1B: return 4'b0001;
            MREQ_WSIZE_2B: return 4'b0011;
            MREQ_WSIZE_4B: return 4'b1111;
            default:       return 4'b0011;
        endcase
    endfunction

endpackage

// File: rtl/mreq_exec_timer.sv
// Access watchdog: reloads while idle, counts down while the strobe is up and
// flags expiry after TIMEOUT_CYCLES strobe cycles.
module mreq_exec_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic load,
    input  logic run,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Down-counter with reload; holds at zero once expired.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= CNT_INIT;
        end else if (run && (count_r != '0)) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = run && (count_r == '0);

endmodule

// File: rtl/mreq_exec.sv
// Memory-request executor: runs one mreq as a series of single-word bus
// accesses. Define MREQ_EXEC_TIMEOUT_EN to abort accesses that never ack.
module mreq_exec
    import mreq_exec_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mreq_valid,
    output logic                 o_mreq_ready,
    input  logic [MREQ_NBIT-1:0] i_mreq,
    input  logic                 i_wdata_valid,
    input  logic [7:0]           i_wdata,
    output logic                 o_wdata_ready,
    output logic                 o_rdata_valid,
    output logic [7:0]           o_rdata,
    input  logic                 i_rdata_ready,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [31:0]          o_wb_adr,
    output logic [31:0]          o_wb_dat,
    output logic [3:0]           o_wb_sel,
    input  logic [31:0]          i_wb_dat,
    input  logic                 i_wb_ack,
    output logic                 o_err_timeout
);
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WR_GATHER = 3'd1;
    localparam logic [2:0] ST_WR_BUS    = 3'd2;
    localparam logic [2:0] ST_RD_BUS    = 3'd3;
    localparam logic [2:0] ST_RD_SEND   = 3'd4;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]  state_r;
    logic        mreq_ready_r, wdata_ready_r, rdata_valid_r, err_r;
    logic        cyc_r, stb_r, we_r, aincr_r;
    logic [31:0] adr_r, dat_r, rd_word_r;
    logic [3:0]  sel_r;
    logic [7:0]  rdata_r, words_left_r;
    logic [1:0]  byte_idx_r, last_idx_r;

    mreq_t       mreq_s;
    logic        accept_s, wbyte_s, rbyte_s, ack_s, timeout_s, done_s;
    logic        last_word_s, last_byte_s;
    logic [1:0]  byte_nxt_s;
    logic [31:0] rd_in_s, adr_next_s;

    assign mreq_s      = unpack_mreq(i_mreq);
    assign accept_s    = mreq_ready_r & i_mreq_valid;
    assign wbyte_s     = wdata_ready_r & i_wdata_valid;
    assign rbyte_s     = rdata_valid_r & i_rdata_ready;
    assign ack_s       = stb_r & i_wb_ack;
    assign done_s      = ack_s | timeout_s;
    assign last_word_s = (words_left_r == 8'd0);
    assign last_byte_s = (byte_idx_r == last_idx_r);
    assign byte_nxt_s  = byte_idx_r + 2'd1;
    assign adr_next_s  = adr_r + {31'd0, aincr_r};
    // An aborted read returns zeros so the byte stream keeps its framing.
    assign rd_in_s     = ack_s ? i_wb_dat : 32'h0000_0000;

`ifdef MREQ_EXEC_TIMEOUT_EN
    logic expire_s;

    mreq_exec_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .load  (~stb_r),
        .run   (stb_r),
        .expire(expire_s)
    );

    assign timeout_s = expire_s & ~i_wb_ack;
`else
    assign timeout_s = 1'b0;
`endif

    // Request sequencer and all registered bus/stream outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r       <= ST_IDLE;
            mreq_ready_r  <= 1'b0;
            wdata_ready_r <= 1'b0;
            rdata_valid_r <= 1'b0;
            err_r         <= 1'b0;
            cyc_r         <= 1'b0;
            stb_r         <= 1'b0;
            we_r          <= 1'b0;
            aincr_r       <= 1'b0;
            adr_r         <= 32'h0000_0000;
            dat_r         <= 32'h0000_0000;
            rd_word_r     <= 32'h0000_0000;
            sel_r         <= 4'h0;
            rdata_r       <= 8'h00;
            words_left_r  <= 8'h00;
            byte_idx_r    <= 2'd0;
            last_idx_r    <= 2'd0;
        end else begin
            err_r <= timeout_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mreq_ready_r <= 1'b0;
                        cyc_r        <= 1'b1;
                        we_r         <= mreq_s.wr;
                        aincr_r      <= mreq_s.aincr;
                        adr_r        <= mreq_s.addr;
                        sel_r        <= wsize_sel(mreq_s.wsize);
                        last_idx_r   <= wsize_last_byte(mreq_s.wsize);
                        words_left_r <= mreq_s.wcount;
                        byte_idx_r   <= 2'd0;
                        dat_r        <= 32'h0000_0000;
                        if (mreq_s.wr) begin
                            wdata_ready_r <= 1'b1;
                            state_r       <= ST_WR_GATHER;
                        end else begin
                            stb_r   <= 1'b1;
                            state_r <= ST_RD_BUS;
                        end
                    end else begin
                        mreq_ready_r <= 1'b1;
                    end
                end
                ST_WR_GATHER: begin
                    if (wbyte_s) begin
                        dat_r[{byte_idx_r, 3'b000} +: 8] <= i_wdata;
                        if (last_byte_s) begin
                            wdata_ready_r <= 1'b0;
                            stb_r         <= 1'b1;
                            byte_idx_r    <= 2'd0;
                            state_r       <= ST_WR_BUS;
                        end else begin
                            byte_idx_r <= byte_nxt_s;
                        end
                    end
                end
                ST_WR_BUS: begin
                    if (done_s) begin
                        stb_r <= 1'b0;
                        adr_r <= adr_next_s;
                        if (last_word_s) begin
                            cyc_r        <= 1'b0;
                            we_r         <= 1'b0;
                            mreq_ready_r <= 1'b1;
                            state_r      <= ST_IDLE;
                        end else begin
                            words_left_r  <= words_left_r - 8'd1;
                            dat_r         <= 32'h0000_0000;
                            wdata_ready_r <= 1'b1;
                            state_r       <= ST_WR_GATHER;
                        end
                    end
                end
                ST_RD_BUS: begin
                    if (done_s) begin
                        stb_r         <= 1'b0;
                        adr_r         <= adr_next_s;
                        rd_word_r     <= rd_in_s;
                        rdata_r       <= rd_in_s[7:0];
                        rdata_valid_r <= 1'b1;
                        byte_idx_r    <= 2'd0;
                        state_r       <= ST_RD_SEND;
                    end
                end
                ST_RD_SEND: begin
                    if (rbyte_s) begin
                        if (last_byte_s) begin
                            rdata_valid_r <= 1'b0;
                            byte_idx_r    <= 2'd0;
                            if (last_word_s) begin
                                cyc_r        <= 1'b0;
                                we_r         <= 1'b0;
                                mreq_ready_r <= 1'b1;
                                state_r      <= ST_IDLE;
                            end else begin
                                words_left_r <= words_left_r - 8'd1;
                                stb_r        <= 1'b1;
                                state_r      <= ST_RD_BUS;
                            end
                        end else begin
                            byte_idx_r <= byte_nxt_s;
                            rdata_r    <= rd_word_r[{byte_nxt_s, 3'b000} +: 8];
                        end
                    end
                end
                default: begin
                    cyc_r         <= 1'b0;
                    stb_r         <= 1'b0;
                    we_r          <= 1'b0;
                    wdata_ready_r <= 1'b0;
                    rdata_valid_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mreq_ready  = mreq_ready_r;
    assign o_wdata_ready = wdata_ready_r;
    assign o_rdata_valid = rdata_valid_r;
    assign o_rdata       = rdata_r;
    assign o_wb_cyc      = cyc_r;
    assign o_wb_stb      = stb_r;
    assign o_wb_we       = we_r;
    assign o_wb_adr      = adr_r;
    assign o_wb_dat      = dat_r;
    assign o_wb_sel      = sel_r;
    assign o_err_timeout = err_r;

endmodule
